// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: datapath widths, ALU operation codes,
// operand forward-select encodings and the ID/EX register layout.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int NREG_BITS = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // All-zero value of this struct is the bubble: invalid, no side effects, ADD.
  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [XLEN-1:0]      imm;
    logic [NREG_BITS-1:0] rs1;
    logic [NREG_BITS-1:0] rs2;
    logic [NREG_BITS-1:0] rd;
    logic [3:0]           alu_ctrl;
    logic                 alu_src;
    logic                 a_pc;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Combinational operand select for one source register: EX/MEM result,
// MEM/WB writeback data, or the value latched in ID/EX. x0 never forwards.
module fwd_mux
  import riscv_pkg::*;
(
  input  logic [NREG_BITS-1:0] src_idx,
  input  logic [XLEN-1:0]      reg_data,
  input  logic                 exmem_reg_write,
  input  logic [NREG_BITS-1:0] exmem_rd,
  input  logic [XLEN-1:0]      exmem_alu_out,
  input  logic                 memwb_reg_write,
  input  logic [NREG_BITS-1:0] memwb_rd,
  input  logic [XLEN-1:0]      memwb_wb_data,
  output logic [XLEN-1:0]      fwd_data
);

  fwd_sel_e sel_s;

  // Pick the youngest producer; EX/MEM is newer than MEM/WB so it wins.
  always_comb begin
    sel_s = FWD_REG;
    if (exmem_reg_write && (exmem_rd != {NREG_BITS{1'b0}}) && (exmem_rd == src_idx)) begin
      sel_s = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd != {NREG_BITS{1'b0}}) && (memwb_rd == src_idx)) begin
      sel_s = FWD_MEMWB;
    end else begin
      sel_s = FWD_REG;
    end
  end

  // Data mux driven by the select.
  always_comb begin
    fwd_data = reg_data;
    case (sel_s)
      FWD_EXMEM: fwd_data = exmem_alu_out;
      FWD_MEMWB: fwd_data = memwb_wb_data;
      default:   fwd_data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, WB bypass at
// capture and combinational EX/MEM, MEM/WB forwarding into the ALU operands.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [NREG_BITS-1:0] id_rs1,
  input  logic [NREG_BITS-1:0] id_rs2,
  input  logic [NREG_BITS-1:0] id_rd,
  input  logic [3:0]           id_alu_ctrl,
  input  logic                 id_alu_src,
  input  logic                 id_a_pc,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic                 id_mem_to_reg,
  input  logic                 exmem_reg_write,
  input  logic [NREG_BITS-1:0] exmem_rd,
  input  logic [XLEN-1:0]      exmem_alu_out,
  input  logic                 memwb_reg_write,
  input  logic [NREG_BITS-1:0] memwb_rd,
  input  logic [XLEN-1:0]      memwb_wb_data,
  input  logic                 hold,
  input  logic                 flush,
  output logic                 load_use,
  output logic [XLEN-1:0]      ALU_in1,
  output logic [XLEN-1:0]      ALU_in2,
  output logic [3:0]           ALU_ctrl,
  output logic                 ex_valid,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_mem_to_reg,
  output logic [NREG_BITS-1:0] ex_rd,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_store_data
);

  id_ex_t          ex_r;
  id_ex_t          id_s;
  logic            load_use_s;
  logic [XLEN-1:0] fwd_rs1_s;
  logic [XLEN-1:0] fwd_rs2_s;

  // rs2 is compared even for I-type; a spurious stall is cheaper than decoding here.
  assign load_use_s = ex_r.valid && ex_r.mem_read && (ex_r.rd != {NREG_BITS{1'b0}}) && id_valid &&
                      ((ex_r.rd == id_rs1) || (ex_r.rd == id_rs2));

  // Assemble the captured fields; MEM/WB bypass covers a regfile without write-through.
  always_comb begin
    id_s            = '0;
    id_s.valid      = id_valid;
    id_s.pc         = id_pc;
    id_s.imm        = id_imm;
    id_s.rs1        = id_rs1;
    id_s.rs2        = id_rs2;
    id_s.rd         = id_rd;
    id_s.alu_ctrl   = id_alu_ctrl;
    id_s.alu_src    = id_alu_src;
    id_s.a_pc       = id_a_pc;
    id_s.reg_write  = id_reg_write;
    id_s.mem_read   = id_mem_read;
    id_s.mem_write  = id_mem_write;
    id_s.mem_to_reg = id_mem_to_reg;
    if (memwb_reg_write && (memwb_rd != {NREG_BITS{1'b0}}) && (memwb_rd == id_rs1)) begin
      id_s.rs1_data = memwb_wb_data;
    end else begin
      id_s.rs1_data = id_rs1_data;
    end
    if (memwb_reg_write && (memwb_rd != {NREG_BITS{1'b0}}) && (memwb_rd == id_rs2)) begin
      id_s.rs2_data = memwb_wb_data;
    end else begin
      id_s.rs2_data = id_rs2_data;
    end
  end

  // Pipeline register: flush beats hold, hold beats the load-use bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r <= '0;
    end else if (flush) begin
      ex_r <= '0;
    end else if (hold) begin
      ex_r <= ex_r;
    end else if (load_use_s) begin
      ex_r <= '0;
    end else begin
      ex_r <= id_s;
    end
  end

  fwd_mux u_fwd_rs1 (
    .src_idx         (ex_r.rs1),
    .reg_data        (ex_r.rs1_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_alu_out   (exmem_alu_out),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_wb_data   (memwb_wb_data),
    .fwd_data        (fwd_rs1_s)
  );

  fwd_mux u_fwd_rs2 (
    .src_idx         (ex_r.rs2),
    .reg_data        (ex_r.rs2_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_alu_out   (exmem_alu_out),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_wb_data   (memwb_wb_data),
    .fwd_data        (fwd_rs2_s)
  );

  assign load_use      = load_use_s;
  assign ALU_in1       = ex_r.a_pc    ? ex_r.pc  : fwd_rs1_s;
  assign ALU_in2       = ex_r.alu_src ? ex_r.imm : fwd_rs2_s;
  assign ALU_ctrl      = ex_r.alu_ctrl;
  assign ex_valid      = ex_r.valid;
  assign ex_reg_write  = ex_r.reg_write;
  assign ex_mem_read   = ex_r.mem_read;
  assign ex_mem_write  = ex_r.mem_write;
  assign ex_mem_to_reg = ex_r.mem_to_reg;
  assign ex_rd         = ex_r.rd;
  assign ex_pc         = ex_r.pc;
  assign ex_store_data = fwd_rs2_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized
// run compared against a behavioural model of the ID/EX slot.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_a_pc, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_alu_out;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_wb_data;
  logic        hold, flush;
  logic        load_use;
  logic [31:0] ALU_in1, ALU_in2;
  logic [3:0]  ALU_ctrl;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc, ex_store_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
    .id_alu_src(id_alu_src), .id_a_pc(id_a_pc), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_out(exmem_alu_out),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wb_data(memwb_wb_data),
    .hold(hold), .flush(flush), .load_use(load_use), .ALU_in1(ALU_in1), .ALU_in2(ALU_in2),
    .ALU_ctrl(ALU_ctrl), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_store_data(ex_store_data)
  );

  // Model of the instruction sitting in EX, as the ISA-level pipeline sees it.
  typedef struct {
    bit          valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    bit          src, apc, rw, mr, mw, m2r;
  } ex_m_t;

  ex_m_t m;

  logic [142:0] dut_vec;
  assign dut_vec = {load_use, ALU_in1, ALU_in2, ALU_ctrl, ex_valid, ex_reg_write, ex_mem_read,
                    ex_mem_write, ex_mem_to_reg, ex_rd, ex_pc, ex_store_data};

  function automatic ex_m_t bubble();
    ex_m_t b;
    b = '{default: 0};
    return b;
  endfunction

  // Newest writer of register idx, or the latched value; x0 is always its own value.
  function automatic logic [31:0] f_val(logic [4:0] idx, logic [31:0] d);
    if (idx != 5'd0 && exmem_reg_write && exmem_rd == idx) return exmem_alu_out;
    if (idx != 5'd0 && memwb_reg_write && memwb_rd == idx) return memwb_wb_data;
    return d;
  endfunction

  function automatic logic f_lu();
    return m.valid && m.mr && m.rd != 5'd0 && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  function automatic logic [142:0] exp_vec();
    logic [31:0] a, b, s;
    s = f_val(m.rs2, m.d2);
    a = m.apc ? m.pc : f_val(m.rs1, m.d1);
    b = m.src ? m.imm : s;
    return {f_lu(), a, b, m.op, m.valid, m.rw, m.mr, m.mw, m.m2r, m.rd, m.pc, s};
  endfunction

  task automatic tick();
    ex_m_t n;
    if (flush) n = bubble();
    else if (hold) n = m;
    else if (f_lu()) n = bubble();
    else begin
      n.valid = id_valid; n.pc = id_pc; n.imm = id_imm;
      n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.op = id_alu_ctrl;
      n.src = id_alu_src; n.apc = id_a_pc; n.rw = id_reg_write; n.mr = id_mem_read;
      n.mw = id_mem_write; n.m2r = id_mem_to_reg;
      n.d1 = (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == id_rs1) ? memwb_wb_data : id_rs1_data;
      n.d2 = (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == id_rs2) ? memwb_wb_data : id_rs2_data;
    end
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_pc = 32'd0; id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_alu_ctrl = 4'd0; id_alu_src = 1'b0;
    id_a_pc = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    id_mem_to_reg = 1'b0; exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_alu_out = 32'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_wb_data = 32'd0; hold = 1'b0; flush = 1'b0;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                           input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                           input logic [31:0] imm, input logic [3:0] op, input logic src,
                           input logic rw, input logic mr, input logic mw);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
    id_rd = rd; id_imm = imm; id_alu_ctrl = op; id_alu_src = src; id_a_pc = 1'b0;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = mr;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (dut_vec !== 143'd0) begin
      n_fail++; $display("FAIL reset_por: got %h expected 0", dut_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m = bubble();
    set_instr(32'h40, 5'd3, 32'h11, 5'd4, 32'h22, 5'd9, 32'd0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    hold = 1'b1;
    tick();
    #2;  // mid-cycle, away from any clock edge
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== 143'd0 || ALU_ctrl !== 4'b0000) begin
      n_fail++; $display("FAIL reset_async: got %h expected 0", dut_vec);
    end
    m = bubble();
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
  endtask

  task automatic test_add();
    idle();
    set_instr(32'h100, 5'd5, 32'd7, 5'd6, 32'd9, 5'd7, 32'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    n_checks++;
    if ({ALU_in1, ALU_in2, ALU_ctrl, ex_valid} !== {32'd7, 32'd9, 4'b0000, 1'b1}) begin
      n_fail++; $display("FAIL add: got %h %h %h %b expected 7 9 0 1", ALU_in1, ALU_in2, ALU_ctrl, ex_valid);
    end
  endtask

  task automatic test_fwd_priority();
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_alu_out = 32'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_wb_data = 32'hBB;
    #1;
    n_checks++;
    if (ALU_in1 !== 32'hAA) begin
      n_fail++; $display("FAIL fwd_exmem_wins: got %h expected aa", ALU_in1);
    end
    exmem_reg_write = 1'b0;
    #1;
    n_checks++;
    if (ALU_in1 !== 32'hBB) begin
      n_fail++; $display("FAIL fwd_memwb: got %h expected bb", ALU_in1);
    end
    memwb_rd = 5'd0;
    #1;
    n_checks++;
    if (ALU_in1 !== 32'd7) begin
      n_fail++; $display("FAIL fwd_x0_none: got %h expected 7", ALU_in1);
    end
    idle();
  endtask

  task automatic test_load_use();
    idle();
    set_instr(32'h200, 5'd1, 32'd0, 5'd0, 32'd0, 5'd3, 32'd8, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_instr(32'h204, 5'd4, 32'd1, 5'd3, 32'd2, 5'd8, 32'd0, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (load_use !== 1'b1) begin
      n_fail++; $display("FAIL load_use_hit: got %b expected 1", load_use);
    end
    tick();
    n_checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_rd, ALU_ctrl} !== 14'd0) begin
      n_fail++; $display("FAIL load_use_bubble: got %b%b%b%b%b %h %h expected all 0",
                         ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_rd, ALU_ctrl);
    end
    set_instr(32'h300, 5'd1, 32'd0, 5'd0, 32'd0, 5'd0, 32'd8, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_instr(32'h304, 5'd0, 32'd1, 5'd0, 32'd2, 5'd8, 32'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (load_use !== 1'b0) begin
      n_fail++; $display("FAIL load_use_x0: got %b expected 0", load_use);
    end
    tick();
    idle();
  endtask

  task automatic test_hold_flush();
    logic [31:0] v;
    idle();
    set_instr(32'h500, 5'd8, 32'h1, 5'd2, 32'h2, 5'd9, 32'd0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr($urandom, 5'($urandom), $urandom, 5'($urandom), $urandom, 5'($urandom), $urandom,
                4'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
      v = $urandom;
      exmem_reg_write = 1'b1; exmem_rd = 5'd8; exmem_alu_out = v;
      #1;
      n_checks++;
      if (ALU_in1 !== v) begin
        n_fail++; $display("FAIL hold_fwd_track: got %h expected %h", ALU_in1, v);
      end
      tick();
      n_checks++;
      if ({ex_pc, ex_rd, ALU_ctrl, ex_valid} !== {32'h500, 5'd9, 4'b0100, 1'b1}) begin
        n_fail++; $display("FAIL hold_keep: got %h %h %h %b expected 500 9 4 1", ex_pc, ex_rd, ALU_ctrl, ex_valid);
      end
    end
    flush = 1'b1;
    tick();
    n_checks++;
    if ({ex_valid, ex_rd, ex_pc, ex_reg_write} !== 39'd0) begin
      n_fail++; $display("FAIL flush_hold: got %b %h %h %b expected 0", ex_valid, ex_rd, ex_pc, ex_reg_write);
    end
    idle();
  endtask

  task automatic test_store();
    idle();
    set_instr(32'h600, 5'd2, 32'h80, 5'd10, 32'h5555, 5'd0, 32'd16, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    memwb_reg_write = 1'b1; memwb_rd = 5'd10; memwb_wb_data = 32'h1234;
    #1;
    n_checks++;
    if ({ALU_in2, ex_store_data, ex_mem_write} !== {32'd16, 32'h1234, 1'b1}) begin
      n_fail++; $display("FAIL store: got %h %h %b expected 10 1234 1", ALU_in2, ex_store_data, ex_mem_write);
    end
    idle();
  endtask

  task automatic test_wb_bypass();
    idle();
    set_instr(32'h700, 5'd5, 32'h1, 5'd6, 32'h2, 5'd7, 32'd0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_wb_data = 32'hCAFE;
    tick();
    idle();
    #1;
    n_checks++;
    if ({ALU_in1, ALU_in2} !== {32'hCAFE, 32'h2}) begin
      n_fail++; $display("FAIL wb_bypass: got %h %h expected cafe 2", ALU_in1, ALU_in2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 7) != 0); id_pc = $urandom; id_imm = $urandom;
      id_rs1_data = $urandom; id_rs2_data = $urandom;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
      id_alu_ctrl = 4'($urandom); id_alu_src = 1'($urandom); id_a_pc = ($urandom_range(0, 3) == 0);
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_alu_out = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_wb_data = $urandom;
      hold = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 15) == 0);
      #1;
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_add();
    test_fwd_priority();
    test_load_use();
    test_hold_flush();
    test_store();
    test_wb_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage directly upstream of the ALU.
- Captures decoded fields from ID and resolves data hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles.
- Drives ALU_in1, ALU_in2 and ALU_ctrl, plus the control and store-data fields that travel on to EX/MEM.

Parameters:
- XLEN, 32, datapath width.
- NREG_BITS, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  NREG_BITS  register indices
- id_alu_ctrl  in  4  ALU operation code
- id_alu_src  in  1  0: in2 = rs2, 1: in2 = imm
- id_a_pc  in  1  1: in1 = PC (AUIPC/JAL)
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  decoded controls
- exmem_reg_write  in  1  EX/MEM writes a register
- exmem_rd  in  NREG_BITS  EX/MEM destination
- exmem_alu_out  in  XLEN  EX/MEM result
- memwb_reg_write  in  1  MEM/WB writes a register
- memwb_rd  in  NREG_BITS  MEM/WB destination
- memwb_wb_data  in  XLEN  MEM/WB writeback data
- hold  in  1  downstream stall; freeze register
- flush  in  1  branch/jump redirect; kill contents
- load_use  out  1  combinational; ID/IF must hold this cycle
- ALU_in1, ALU_in2  out  XLEN  ALU operands
- ALU_ctrl  out  4  ALU operation
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered controls
- ex_rd  out  NREG_BITS  registered destination
- ex_pc  out  XLEN  registered PC
- ex_store_data  out  XLEN  forwarded rs2 value for stores

Behaviour:
- Reset is asynchronous on rst_n low. All registered fields clear to 0, which gives ALU_ctrl = 4'b0000 (ADD) and ALU_in1 = ALU_in2 = 0.
- load_use = ex_valid & ex_mem_read & ex_rd != 0 & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
  - Compare against id_rs2 regardless of id_alu_src; this is conservative.
- Register update priority each rising edge:
  1. flush: insert bubble.
  2. hold: keep all fields.
  3. load_use: insert bubble.
  4. Otherwise: capture ID fields.
- Bubble: ex_valid = 0, all control bits 0, ex_rd = 0, ALU_ctrl = ADD, and operand and PC fields cleared.
- WB bypass at capture: if memwb_reg_write, memwb_rd != 0 and memwb_rd == id_rsX, the stored rsX data is memwb_wb_data instead of id_rsX_data. This covers a register file without write-through.
- Forwarding is combinational on the registered rs1/rs2 every cycle, including while hold is asserted. Per operand:
  - If exmem_reg_write, exmem_rd != 0 and exmem_rd == ex_rsX: use exmem_alu_out.
  - Else if memwb_reg_write, memwb_rd != 0 and memwb_rd == ex_rsX: use memwb_wb_data.
  - Else use the registered data.
  - EX/MEM wins when both match.
- Register x0 never forwards and never triggers load_use.
- ALU_in1 = ex_a_pc ? ex_pc : fwd_rs1.
- ALU_in2 = ex_alu_src ? ex_imm : fwd_rs2.
- ex_store_data = fwd_rs2, always.
- Latency: one cycle from ID inputs to registered outputs. Operand outputs follow the forwarding inputs with zero cycles of latency.
- Simultaneous flush and hold: flush wins. Simultaneous hold and load_use: hold wins and the register keeps its contents.
- Reset asserted mid-hold clears immediately, independent of clk.

Decomposition:
- Shared package riscv_pkg holds:
  - ALU_ctrl encodings: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - XLEN and NREG_BITS.
  - Forward-select enum: FWD_REG, FWD_EXMEM, FWD_MEMWB.
- One sub-module, fwd_mux: purely combinational select for one operand. It is instantiated twice, for rs1 and rs2.

Test Plan:
- Reset with rst_n = 0 mid-stream -> all outputs 0 and ALU_ctrl = 0000 immediately, without waiting for a clock edge.
- ADD with rs1 = x5 (data 7) and rs2 = x6 (data 9), no hazards -> next cycle ALU_in1 = 7, ALU_in2 = 9, ALU_ctrl = 0000, ex_valid = 1.
- ex_rs1 = x5 with exmem_rd = 5 (0xAA) and memwb_rd = 5 (0xBB), both writing -> ALU_in1 = 0xAA. Deassert exmem_reg_write -> ALU_in1 = 0xBB.
- ex instruction is LW to x3 and ID reads x3 -> load_use = 1, and next cycle ex_valid = 0 with all controls 0. Repeat with rd = x0 -> load_use = 0.
- hold = 1 for 3 cycles with ID inputs changing -> registered fields unchanged while ALU_in1 tracks a changing exmem_alu_out. flush with hold -> bubble.
- SW with imm = 16 and id_alu_src = 1, while rs2 is forwarded from memwb (0x1234) -> ALU_in2 = 16, ex_store_data = 0x1234.
